// File: rtl/cfg_mem_mp_rw.sv
// cfg_mem_mp_rw: runtime-writable neuron config memory with NUM_RD registered read channels and a clear sequencer
// Ports:
//   clk_i, rst_i                     clock (rising edge), asynchronous active-high reset
//   rd_en_i, rd_addr_i               per-channel read enable, packed per-channel addresses
//   rd_data_o, rd_vld_o              per-channel registered read data, one-cycle valid
//   wr_vld_i, wr_rdy_o               write handshake; ready only while idle
//   wr_addr_i, wr_data_i, wr_mask_i  masked write (mask bit 1 = update that bit)
//   clr_start_i, busy_o, clr_done_o  clear sequencer start, in-progress flag, completion pulse
//   addr_err_o                       sticky out-of-range flag, cleared only by reset
module cfg_mem_mp_rw #(
    parameter int                NUM_NURNS  = 256,
    parameter int                ADDR_W     = 8,
    parameter int                WORD_W     = 50,
    parameter int                NUM_RD     = 3,
    parameter logic [WORD_W-1:0] INIT_VAL   = '0,
    parameter bit                CLR_ON_RST = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*WORD_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_vld_o,
    input  logic                     wr_vld_i,
    output logic                     wr_rdy_o,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [WORD_W-1:0]        wr_data_i,
    input  logic [WORD_W-1:0]        wr_mask_i,
    input  logic                     clr_start_i,
    output logic                     busy_o,
    output logic                     clr_done_o,
    output logic                     addr_err_o
);
    // one extra bit so a full 2^ADDR_W depth is representable
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_NURNS);
    localparam logic [ADDR_W:0] LAST  = DEPTH - 1'b1;
    // index width matched to the array; in-range addresses truncate losslessly
    localparam int IDX_W = (NUM_NURNS > 1) ? $clog2(NUM_NURNS) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t state, state_nxt;
    logic [ADDR_W:0] cnt;
    logic [WORD_W-1:0] mem [NUM_NURNS];

    logic clearing, wr_acc, wr_ok, we;
    logic [ADDR_W-1:0] wa;
    logic [WORD_W-1:0] wd;
    logic [ADDR_W-1:0] ra [NUM_RD];
    logic [NUM_RD-1:0] rd_ok;
    logic [WORD_W-1:0] rd_word [NUM_RD];

    always_comb begin
        state_nxt = (state == IDLE) ? (clr_start_i ? CLEAR : IDLE)
                                    : ((cnt == LAST) ? IDLE : CLEAR);
    end

    assign wr_rdy_o = (state == IDLE);
    assign busy_o   = (state == CLEAR);

    // the array is not reset, so suppress clear writes while reset is held
    assign clearing = busy_o & ~rst_i;
    assign wr_acc   = wr_vld_i & wr_rdy_o;
    assign wr_ok    = {1'b0, wr_addr_i} < DEPTH;

    // single array write port shared by host writes and the clear sequencer;
    // they never collide because the host port is only ready in IDLE
    assign we = clearing | (wr_acc & wr_ok);
    assign wa = clearing ? cnt[ADDR_W-1:0] : wr_addr_i;
    assign wd = clearing ? INIT_VAL
                         : (mem[wr_addr_i[IDX_W-1:0]] & ~wr_mask_i) | (wr_data_i & wr_mask_i);

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            assign ra[k]      = rd_addr_i[k*ADDR_W +: ADDR_W];
            assign rd_ok[k]   = {1'b0, ra[k]} < DEPTH;
            // write-first: a same-cycle write to this address is forwarded
            assign rd_word[k] = !rd_ok[k] ? '0
                              : (we && wa == ra[k]) ? wd
                              : mem[ra[k][IDX_W-1:0]];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (we)
            mem[wa[IDX_W-1:0]] <= wd;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= CLR_ON_RST ? CLEAR : IDLE;
            cnt        <= '0;
            clr_done_o <= 1'b0;
            addr_err_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= (state == IDLE) ? '0 : cnt + 1'b1;
            clr_done_o <= busy_o && cnt == LAST;
            addr_err_o <= addr_err_o | (|(rd_en_i & ~rd_ok)) | (wr_acc & ~wr_ok);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
            rd_vld_o  <= '0;
        end else begin
            rd_vld_o <= rd_en_i;
            for (int i = 0; i < NUM_RD; i++)
                if (rd_en_i[i])
                    rd_data_o[i*WORD_W +: WORD_W] <= rd_word[i];
        end
    end
endmodule
